// File: rtl/bcd_event_counter.sv
// Packed-BCD event counter with a periodic frozen snapshot and a one-cycle refresh trigger.
// Optional feature macro PRESET_EN adds a `load` input that copies PRESET_VALUE into the live count.
module bcd_event_counter #(
    parameter int          DIGITS         = 6,
    parameter int          REFRESH_CYCLES = 1000,
    parameter logic [31:0] PRESET_VALUE   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse_in,
    input  logic        up_dn,
    input  logic        clear,
    input  logic        hold,
`ifdef PRESET_EN
    input  logic        load,
`endif
    output logic [31:0] cnt_out,
    output logic        trigger,
    output logic        overflow
);

    localparam int          NBITS      = 4 * DIGITS;
    localparam logic [31:0] DIGIT_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                                       : ((32'h1 << NBITS) - 32'h1);
    localparam int          RW         = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [RW-1:0] REF_ZERO = RW'(0);
    localparam logic [RW-1:0] REF_ONE  = RW'(1);

    logic          r_pulse_meta;
    logic          r_pulse_sync;
    logic          r_pulse_prev;
    logic          r_up_meta;
    logic          r_up_sync;
    logic [31:0]   r_live;
    logic          r_overflow;
    logic [RW-1:0] r_refresh;
    logic [31:0]   r_cnt_out;
    logic          r_trigger;

    logic          w_event;
    logic [32:0]   w_step;
    logic [31:0]   w_live_nxt;
    logic          w_ovf_nxt;

    // One BCD step over DIGITS decades; bit 32 reports a wrap of the whole count.
    // Non-BCD digits are read as 0 so a corrupted digit heals on the next update.
    function automatic logic [32:0] bcd_step(input logic [31:0] value, input logic up);
        logic [31:0] res;
        logic        carry;
        logic [3:0]  d;
        res   = 32'h0;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = (value[4*i +: 4] > 4'd9) ? 4'd0 : value[4*i +: 4];
            if (carry == 1'b0) begin
                res[4*i +: 4] = d;
            end else if (up) begin
                res[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                carry         = (d == 4'd9);
            end else begin
                res[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                carry         = (d == 4'd0);
            end
        end
        return {carry, res};
    endfunction

    assign w_event = r_pulse_sync & ~r_pulse_prev;

    // Two-flop synchronisers for the asynchronous pulse and direction inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_meta <= 1'b0;
            r_pulse_sync <= 1'b0;
            r_pulse_prev <= 1'b0;
            r_up_meta    <= 1'b0;
            r_up_sync    <= 1'b0;
        end else begin
            r_pulse_meta <= pulse_in;
            r_pulse_sync <= r_pulse_meta;
            r_pulse_prev <= r_pulse_sync;
            r_up_meta    <= up_dn;
            r_up_sync    <= r_up_meta;
        end
    end

    // Next live count: clear beats load beats hold beats event; losers are dropped.
    always_comb begin
        w_step     = bcd_step(r_live, r_up_sync);
        w_live_nxt = r_live;
        w_ovf_nxt  = r_overflow;
        if (clear) begin
            w_live_nxt = 32'h0;
            w_ovf_nxt  = 1'b0;
        end
`ifdef PRESET_EN
        else if (load) begin
            w_live_nxt = PRESET_VALUE & DIGIT_MASK;
            w_ovf_nxt  = r_overflow;
        end
`endif
        else if (hold) begin
            w_live_nxt = r_live;
            w_ovf_nxt  = r_overflow;
        end else if (w_event) begin
            w_live_nxt = w_step[31:0];
            w_ovf_nxt  = r_overflow | w_step[32];
        end else begin
            w_live_nxt = r_live;
            w_ovf_nxt  = r_overflow;
        end
    end

    // Live count and sticky wrap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 32'h0;
            r_overflow <= 1'b0;
        end else begin
            r_live     <= w_live_nxt;
            r_overflow <= w_ovf_nxt;
        end
    end

    // Refresh timer: on its wrap the snapshot takes the pre-event live count and trigger pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= REF_ZERO;
            r_cnt_out <= 32'h0;
            r_trigger <= 1'b0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= REF_ZERO;
            r_cnt_out <= r_live;
            r_trigger <= 1'b1;
        end else begin
            r_refresh <= r_refresh + REF_ONE;
            r_cnt_out <= r_cnt_out;
            r_trigger <= 1'b0;
        end
    end

`ifndef PRESET_EN
    logic w_unused_preset;
    assign w_unused_preset = ^PRESET_VALUE;
`endif

    assign cnt_out  = r_cnt_out;
    assign trigger  = r_trigger;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Bench for bcd_event_counter: a 6-digit and a 2-digit instance share stimulus and are
// compared every cycle against an integer-arithmetic model, plus literal spot checks.
module tb_bcd_event_counter;

    localparam int          R      = 100;
    localparam logic [31:0] PV     = 32'h00123456;
    localparam int          PV_INT = 123456;
    localparam int          MOD6   = 1000000;
    localparam int          MOD2   = 100;

    logic        clk = 1'b0;
    logic        rst_n, pulse_in, up_dn, clear, hold;
`ifdef PRESET_EN
    logic        load;
`endif
    logic [31:0] cnt6, cnt2;
    logic        trig6, trig2, ovf6, ovf2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_event_counter #(.DIGITS(6), .REFRESH_CYCLES(R), .PRESET_VALUE(PV)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .up_dn(up_dn),
        .clear(clear), .hold(hold),
`ifdef PRESET_EN
        .load(load),
`endif
        .cnt_out(cnt6), .trigger(trig6), .overflow(ovf6));

    bcd_event_counter #(.DIGITS(2), .REFRESH_CYCLES(R), .PRESET_VALUE(PV)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .up_dn(up_dn),
        .clear(clear), .hold(hold),
`ifdef PRESET_EN
        .load(load),
`endif
        .cnt_out(cnt2), .trigger(trig2), .overflow(ovf2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int digits);
        logic [31:0] r;
        int          x;
        r = 32'h0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic count_step(inout int live, inout bit ov, input bit up, input int modulus);
        if (up) begin
            if (live == modulus - 1) begin live = 0; ov = 1'b1; end
            else live = live + 1;
        end else begin
            if (live == 0) begin live = modulus - 1; ov = 1'b1; end
            else live = live - 1;
        end
    endtask

    // Reference model: integer counts, events land two edges after the edge that samples a rise.
    int edge_n, live6, live2, snap6, snap2;
    bit ov6, ov2, trig_exp, last_pulse, ev, ev_dir;
    int due_cyc[$];
    bit due_dir[$];

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                edge_n = 0; live6 = 0; live2 = 0; snap6 = 0; snap2 = 0;
                ov6 = 1'b0; ov2 = 1'b0; trig_exp = 1'b0; last_pulse = 1'b0;
                due_cyc.delete();
                due_dir.delete();
            end else begin
                edge_n++;
                trig_exp = (edge_n % R == 0);
                if (trig_exp) begin snap6 = live6; snap2 = live2; end
                ev = 1'b0;
                ev_dir = 1'b0;
                if (due_cyc.size() > 0 && due_cyc[0] == edge_n) begin
                    ev = 1'b1;
                    ev_dir = due_dir[0];
                    void'(due_cyc.pop_front());
                    void'(due_dir.pop_front());
                end
                if (clear) begin
                    live6 = 0; live2 = 0; ov6 = 1'b0; ov2 = 1'b0;
                end
`ifdef PRESET_EN
                else if (load) begin
                    live6 = PV_INT % MOD6;
                    live2 = PV_INT % MOD2;
                end
`endif
                else if (hold) begin
                    live6 = live6;
                end else if (ev) begin
                    count_step(live6, ov6, ev_dir, MOD6);
                    count_step(live2, ov2, ev_dir, MOD2);
                end
                if (pulse_in && !last_pulse) begin
                    due_cyc.push_back(edge_n + 2);
                    due_dir.push_back(up_dn);
                end
                last_pulse = pulse_in;
            end
            check("cnt_out6",  cnt6,  to_bcd(snap6, 6));
            check("cnt_out2",  cnt2,  to_bcd(snap2, 2));
            check("trigger6",  {31'b0, trig6}, {31'b0, trig_exp});
            check("trigger2",  {31'b0, trig2}, {31'b0, trig_exp});
            check("overflow6", {31'b0, ovf6},  {31'b0, ov6});
            check("overflow2", {31'b0, ovf2},  {31'b0, ov2});
        end
    end

    task automatic pulse_edges(input int count, input int gap);
        for (int k = 0; k < count; k++) begin
            @(negedge clk) pulse_in = 1'b1;
            @(negedge clk) pulse_in = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic wait_trig(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < R + 20; i++) begin
            @(posedge clk);
            #1;
            if (trig6) begin found = 1'b1; break; end
        end
        check(name, {31'b0, found}, 32'd1);
    endtask

    task automatic release_and_time(input string name);
        int cyc;
        cyc = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2 * R; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (trig6) break;
        end
        check(name, cyc, R);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0; pulse_in = 1'b0; up_dn = 1'b1; clear = 1'b0; hold = 1'b0;
`ifdef PRESET_EN
        load = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_cnt", cnt6, 32'h0);
        check("rst_trig", {31'b0, trig6}, 32'h0);
        check("rst_ovf", {31'b0, ovf6}, 32'h0);
        release_and_time("first_trigger_delay");

        // Five spaced edges up.
        pulse_edges(5, 4);
        wait_trig("t1_trig");
        check("t1_cnt", cnt6, 32'h00000005);
        check("t1_ovf", {31'b0, ovf6}, 32'h0);

        // Decade carry, then 2-digit instance reaches 99 and wraps.
        do_clear();
        pulse_edges(10, 4);
        wait_trig("t2_trig_a");
        check("t2_carry", cnt6, 32'h00000010);
        pulse_edges(89, 2);
        wait_trig("t2_trig_b");
        check("t2_d2_99", cnt2, 32'h00000099);
        check("t2_d2_ovf0", {31'b0, ovf2}, 32'h0);
        pulse_edges(1, 4);
        wait_trig("t2_trig_c");
        check("t2_d2_wrap", cnt2, 32'h00000000);
        check("t2_d2_ovf1", {31'b0, ovf2}, 32'h1);
        check("t2_d6_100", cnt6, 32'h00000100);

        // Down from zero wraps to all nines; clear zeroes count and flag.
        do_clear();
        @(negedge clk) up_dn = 1'b0;
        repeat (3) @(negedge clk);
        pulse_edges(1, 4);
        wait_trig("t3_trig_a");
        check("t3_down_wrap", cnt6, 32'h00999999);
        check("t3_ovf", {31'b0, ovf6}, 32'h1);
        do_clear();
        wait_trig("t3_trig_b");
        check("t3_clear_cnt", cnt6, 32'h0);
        check("t3_clear_ovf", {31'b0, ovf6}, 32'h0);

        // Edge landing exactly on the snapshot cycle.
        @(negedge clk) up_dn = 1'b1;
        wait_trig("t4_align");
        repeat (98) @(negedge clk);
        pulse_in = 1'b1;
        @(negedge clk) pulse_in = 1'b0;
        wait_trig("t4_trig_a");
        check("t4_snap_pre", cnt6, 32'h0);
        wait_trig("t4_trig_b");
        check("t4_snap_post", cnt6, 32'h00000001);

        // Asynchronous reset in mid-period.
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t4_async_cnt", cnt6, 32'h0);
        check("t4_async_trig", {31'b0, trig6}, 32'h0);
        check("t4_async_ovf", {31'b0, ovf6}, 32'h0);
        repeat (2) @(negedge clk);
        release_and_time("t4_rerelease_delay");

        // Hold drops events; an edge coinciding with clear is dropped.
        pulse_edges(2, 4);
        @(negedge clk) hold = 1'b1;
        pulse_edges(3, 4);
        repeat (4) @(negedge clk);
        hold = 1'b0;
        wait_trig("t5_trig_a");
        check("t5_hold", cnt6, 32'h00000002);
        pulse_edges(1, 4);
        @(negedge clk) pulse_in = 1'b1;
        @(negedge clk) pulse_in = 1'b0;
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        repeat (4) @(negedge clk);
        wait_trig("t5_trig_b");
        check("t5_clear_drop", cnt6, 32'h0);

`ifdef PRESET_EN
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        pulse_edges(1, 4);
        wait_trig("t6_trig");
        check("t6_preset6", cnt6, 32'h00123457);
        check("t6_preset2", cnt2, 32'h00000057);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
